shift_share_arb: RTL

Shares one 32-bit shift datapath between NREQ requesters (e.g. execute-stage ALU and load/store byte-lane alignment) with round-robin arbitration and valid/ready handshakes. It accepts at most one shift per cycle, registers the result, and returns it tagged with the requester index. It sits beside the ALU in the execute stage. It replaces per-requester shifter instances when area is tight.

---
 rtl/shift_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/shift_share_arb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the shared shift datapath
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;
  localparam logic [1:0] SH_SRL = 2'b10;
  localparam logic [1:0] SH_ILL = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at a pointer
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  // Scan NREQ slots starting at ptr_i, wrapping, and take the first request seen
  always_comb begin
    logic found;
    int   c;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr_i) + k;
      if (c >= NREQ) c = c - NREQ;
      if (en_i && !found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/shift_share_arb.sv
// rtl/shift_share_arb.sv - one registered 32-bit shifter shared round-robin by NREQ requesters
module shift_share_arb #(
  parameter  int NREQ = 2,
  parameter  int XLEN = 32,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid,
  output logic [NREQ-1:0]                   req_ready,
  input  logic [NREQ*XLEN-1:0]              req_in,
  input  logic [NREQ*shift_pkg::SHAMT_W-1:0] req_shamt,
  input  logic [NREQ*2-1:0]                 req_op,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [XLEN-1:0]                   resp_data,
  output logic [IDW-1:0]                    resp_id,
  output logic                              resp_err,
  output logic                              busy
);

  import shift_pkg::*;

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [XLEN-1:0]      resp_data_q, resp_data_d;
  logic [IDW-1:0]       resp_id_q, resp_id_d;
  logic                 resp_err_q, resp_err_d;

  logic                 arb_en;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 xfer;

  logic [XLEN-1:0]      sel_in;
  logic [SHAMT_W-1:0]   sel_shamt;
  logic [1:0]           sel_op;
  logic signed [XLEN-1:0] sra_in;
  logic [XLEN-1:0]      shift_res;
  logic                 shift_err;

  // Grants are offered only when the result register can take a new value;
  // held low during reset so nothing looks accepted while the block is cleared.
  assign arb_en = rst_n & ((state_q == ST_EMPTY) | resp_ready);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(gnt & req_valid);

  // Route the granted requester's operands to the shared shifter
  always_comb begin
    sel_in    = '0;
    sel_shamt = '0;
    sel_op    = SH_SLL;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(gnt_idx) == i) begin
        sel_in    = req_in[XLEN*i +: XLEN];
        sel_shamt = req_shamt[SHAMT_W*i +: SHAMT_W];
        sel_op    = req_op[2*i +: 2];
      end
    end
  end

  assign sra_in = sel_in;

  // Shared shifter; the illegal op passes the operand through and flags an error
  always_comb begin
    shift_res = sel_in;
    shift_err = 1'b0;
    case (sel_op)
      SH_SLL:  shift_res = sel_in << sel_shamt;
      SH_SRA:  shift_res = sra_in >>> sel_shamt;
      SH_SRL:  shift_res = sel_in >> sel_shamt;
      default: begin
        shift_res = sel_in;
        shift_err = 1'b1;
      end
    endcase
  end

  // Next state: a transfer always (re)fills the register, a drain alone empties it
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;
    if (xfer) begin
      state_d     = ST_FULL;
      rr_ptr_d    = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
      resp_data_d = shift_res;
      resp_id_d   = gnt_idx;
      resp_err_d  = shift_err;
    end else if (state_q == ST_FULL && resp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      rr_ptr_q    <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign resp_valid = (state_q == ST_FULL);
  assign busy       = resp_valid;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;

endmodule
